vga_sync_gen: RTL

- Consumes the one-cycle pixel strobe from the pixel-rate divider: 25 MHz effective from the 100 MHz system clock.
- Generates 640x480@60 VGA timing:
  - hsync and vsync
  - active-video flag
  - pixel coordinates
  - line-start and frame-start strobes
- Sits between the divider and the pixel/colour generation logic that drives the VGA DAC pins.

---
 rtl/vga_sync_gen.sv | 91 +++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters advanced by a pixel strobe,
// with sync, blanking and line/frame strobes registered alongside the counters.
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_ACT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] x_reg, y_reg;
    logic [9:0] x_next, y_next;
    logic       x_wrap, y_wrap;
    logic       hsync_reg, vsync_reg, video_reg, line_reg, frame_reg;
    logic       hsync_next, vsync_next, video_next;

    // Decode from the post-tick counter values so every registered output
    // lines up with the coordinates it describes.
    always_comb begin
        x_wrap = (x_reg == H_LAST);
        y_wrap = (y_reg == V_LAST);
        x_next = x_wrap ? 10'd0 : x_reg + 10'd1;
        y_next = y_reg;
        if (x_wrap) begin
            y_next = y_wrap ? 10'd0 : y_reg + 10'd1;
        end
        hsync_next = ((x_next >= HS_FIRST) && (x_next <= HS_LAST)) ? SYNC_ACT : !SYNC_ACT;
        vsync_next = ((y_next >= VS_FIRST) && (y_next <= VS_LAST)) ? SYNC_ACT : !SYNC_ACT;
        video_next = (x_next < H_VIS) && (y_next < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg     <= H_LAST;
            y_reg     <= V_LAST;
            hsync_reg <= !SYNC_ACT;
            vsync_reg <= !SYNC_ACT;
            video_reg <= 1'b0;
            line_reg  <= 1'b0;
            frame_reg <= 1'b0;
        end else if (pix_tick) begin
            x_reg     <= x_next;
            y_reg     <= y_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
            video_reg <= video_next;
            line_reg  <= x_wrap;
            frame_reg <= x_wrap && y_wrap;
        end else begin
            // Strobes mark the tick itself, so they drop on idle cycles.
            line_reg  <= 1'b0;
            frame_reg <= 1'b0;
        end
    end

    assign pixel_x     = x_reg;
    assign pixel_y     = y_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign video_on    = video_reg;
    assign line_start  = line_reg;
    assign frame_start = frame_reg;

endmodule
